data_ram_resp: RTL and testbench

//  Responder end of the MEM-stage data memory interface: accepts ce/we/addr/sel/data requests and serves word,

---
 rtl/data_ram_resp_pkg.sv | 27 ++
 rtl/data_ram_resp_bank.sv | 33 +++
 rtl/data_ram_resp.sv | 135 +++++++++++++
 tb/tb_data_ram_resp.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_resp_pkg.sv
// rtl/data_ram_resp_pkg.sv - shared constants, state encoding and lane helper for the data RAM responder
// Purpose: common definitions imported by data_ram_resp and data_ram_resp_bank.
//   REG_BUS            data bus width
//   DATA_MEM_NUM_LOG2  default storage depth (log2 of 32-bit words)
//   CHIP_ENABLE        active level of ce_i
//   WRITE_ENABLE       active level of we_i
//   dram_state_e       DRAM_IDLE / DRAM_WAIT / DRAM_ACK
// Ports: none.
package data_ram_resp_pkg;

  localparam int   REG_BUS           = 32;
  localparam int   DATA_MEM_NUM_LOG2 = 17;
  localparam logic CHIP_ENABLE       = 1'b1;
  localparam logic WRITE_ENABLE      = 1'b1;

  typedef enum logic [1:0] {
    DRAM_IDLE = 2'd0,
    DRAM_WAIT = 2'd1,
    DRAM_ACK  = 2'd2
  } dram_state_e;

  // Byte lane 'lane' of a bus word; lane 3 is bits 31:24 (byte offset 0).
  function automatic logic [7:0] lane_byte(input logic [REG_BUS-1:0] word, input int lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/data_ram_resp_bank.sv
// rtl/data_ram_resp_bank.sv - one 8-bit byte lane of data storage
// Purpose: byte-wide storage with synchronous write and registered read.
// Ports:
//   clk    in   clock
//   we     in   write enable for this lane
//   re     in   read enable; rdata holds when low
//   addr   in   word index
//   wdata  in   write byte
//   rdata  out  registered read byte
module data_ram_resp_bank #(
  parameter int DEPTH_LOG2 = 17
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Storage is intentionally never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_ram_resp.sv
// rtl/data_ram_resp.sv - MEM-stage data memory responder with configurable wait states
// Purpose: serves big-endian word/halfword/byte reads and writes from four byte-lane
//   banks, stalling the pipeline for WAIT_CYCLES extra cycles per access.
//   Optional macro DATA_RAM_ERR_EN: flag accesses above the storage range with err_o.
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-low reset
//   ce_i        in   request valid, held by the stalled pipeline
//   we_i        in   1 = write, 0 = read
//   addr_i      in   byte address
//   sel_i       in   byte-lane enables, sel_i[3] = bits 31:24
//   data_i      in   lane-replicated write data
//   data_o      out  read data, unselected lanes 0
//   ack_o       out  one-cycle completion pulse
//   stallreq_o  out  pipeline stall request
//   err_o       out  out-of-range access, valid with ack_o
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = DATA_MEM_NUM_LOG2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_i,
  input  logic               we_i,
  input  logic [REG_BUS-1:0] addr_i,
  input  logic [3:0]         sel_i,
  input  logic [REG_BUS-1:0] data_i,
  output logic [REG_BUS-1:0] data_o,
  output logic               ack_o,
  output logic               stallreq_o,
  output logic               err_o
);

  dram_state_e           state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [3:0]            sel_q;
  logic [REG_BUS-1:0]    wdata_q;
  logic                  oor_q;
  logic [3:0]            rd_mask;
  logic [REG_BUS-1:0]    bank_rd;
  logic                  oor;
  logic                  finish;
  logic                  unused_addr;

`ifdef DATA_RAM_ERR_EN
  assign oor         = |addr_i[REG_BUS-1:DEPTH_LOG2+2];
  assign unused_addr = ^addr_i[1:0];
`else
  // Upper address bits are dropped so the address wraps modulo the depth.
  assign oor         = 1'b0;
  assign unused_addr = ^{addr_i[REG_BUS-1:DEPTH_LOG2+2], addr_i[1:0]};
`endif

  // Last WAIT cycle: the edge ending it commits writes and captures read data.
  // Gated by rst so a reset during WAIT discards the pending write.
  assign finish = rst && (state == DRAM_WAIT) && (cnt == 4'd0);

  // In IDLE the stall follows the request so the pipeline freezes in the same cycle.
  assign stallreq_o = (state == DRAM_WAIT) ||
                      ((state == DRAM_IDLE) && (ce_i == CHIP_ENABLE) && rst);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    data_ram_resp_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
      .clk   (clk),
      .we    (finish && (we_q == WRITE_ENABLE) && sel_q[i] && !oor_q),
      .re    (finish && (we_q != WRITE_ENABLE) && !oor_q),
      .addr  (idx_q),
      .wdata (lane_byte(wdata_q, i)),
      .rdata (bank_rd[8*i +: 8])
    );
    // The mask is captured with the read, so the output holds until the next read.
    assign data_o[8*i +: 8] = bank_rd[8*i +: 8] & {8{rd_mask[i]}};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= DRAM_IDLE;
      cnt     <= 4'd0;
      ack_o   <= 1'b0;
      rd_mask <= 4'b0000;
    end else begin
      case (state)
        DRAM_IDLE: begin
          ack_o <= 1'b0;
          if (ce_i == CHIP_ENABLE) begin
            we_q    <= we_i;
            idx_q   <= addr_i[DEPTH_LOG2+1:2];
            sel_q   <= sel_i;
            wdata_q <= data_i;
            oor_q   <= oor;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= DRAM_WAIT;
          end
        end
        DRAM_WAIT: begin
          if (cnt == 4'd0) begin
            ack_o <= 1'b1;
            state <= DRAM_ACK;
            if (we_q != WRITE_ENABLE) begin
              rd_mask <= oor_q ? 4'b0000 : sel_q;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DRAM_ACK: begin
          // ce_i is still the completed request here, so it is not sampled.
          ack_o <= 1'b0;
          state <= DRAM_IDLE;
        end
        default: begin
          ack_o <= 1'b0;
          state <= DRAM_IDLE;
        end
      endcase
    end
  end

`ifdef DATA_RAM_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_o <= 1'b0;
    end else begin
      err_o <= finish && oor_q;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_ram_resp.sv
// tb/tb_data_ram_resp.sv - scoreboard bench for data_ram_resp
module tb_data_ram_resp;

  localparam int DL = 4;
  localparam int W  = 1;
  localparam int NB = 4 << DL;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  sel = '0;
  logic [31:0] rdata;
  logic        ack;
  logic        stall;
  logic        err;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0]  mem_m [NB];
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram_resp #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce),
    .we_i       (we),
    .addr_i     (addr),
    .sel_i      (sel),
    .data_i     (wdata),
    .data_o     (rdata),
    .ack_o      (ack),
    .stallreq_o (stall),
    .err_o      (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_oor(input logic [31:0] a);
`ifdef DATA_RAM_ERR_EN
    return (a >> (DL + 2)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: byte-addressed big-endian memory; lane l of the bus maps to byte offset 3-l.
  task automatic push_exp(input bit w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input int ack_cyc);
    int unsigned base;
    bit o;
    exp_t e;
    base = ((a % NB) / 4) * 4;
    o = is_oor(a);
    if (w) begin
      if (!o) for (int l = 0; l < 4; l++) if (s[l]) mem_m[base + 3 - l] = d[8*l +: 8];
    end else begin
      last_rd = '0;
      if (!o) for (int l = 0; l < 4; l++) if (s[l]) last_rd[8*l +: 8] = mem_m[base + 3 - l];
    end
    e.data = last_rd;
    e.err  = o;
    e.cyc  = ack_cyc;
    exp_q.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; request is first seen this cycle.
  task automatic start(input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input bit track);
    ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
    if (track) push_exp(w, a, s, d, cyc + 2 + W);
    #1;
    check("stall_on_request", stall, 1'b1);
  endtask

  // Wait for ack with a bound, checking stall each cycle; returns at the ack negedge.
  task automatic wait_ack(input bit drop);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (ack) begin
        seen = 1'b1;
        check("stall_low_in_ack", stall, 1'b0);
      end else begin
        check("stall_while_waiting", stall, 1'b1);
        if (drop && k == 0) ce = 1'b0;
      end
    end
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic access(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit drop);
    start(w, a, s, d, 1'b1);
    wait_ack(drop);
    ce = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: compares every ack against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack_cycle", cyc, e.cyc);
        check("data_o", rdata, e.data);
        check("err_o", err, e.err);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pre;
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_data", rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Fill every word so the model knows all contents.
    for (int i = 0; i < NB / 4; i++) access(1'b1, 32'(i * 4), 4'b1111, $urandom, 1'b0);

    // Word write/read, byte write, halfword read.
    access(1'b1, 32'h10, 4'b1111, 32'h11223344, 1'b0);
    access(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
    check("t1_word_read", rdata, 32'h11223344);
    access(1'b1, 32'h11, 4'b0100, 32'hAAAAAAAA, 1'b0);
    access(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
    check("t2_byte_merge", rdata, 32'h11AA3344);
    access(1'b0, 32'h12, 4'b0011, 32'h0, 1'b0);
    check("t2_half_read", rdata, 32'h00003344);
    access(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 1'b0);
    access(1'b0, 32'h10, 4'b0000, 32'h0, 1'b0);
    check("sel0_read", rdata, 32'h0);

    // Back-to-back reads with ce held across both.
    start(1'b0, 32'h10, 4'b1111, 32'h0, 1'b1);
    wait_ack(1'b0);
    addr = 32'h4;
    push_exp(1'b0, 32'h4, 4'b1111, 32'h0, cyc + 3 + W);
    wait_ack(1'b0);
    ce = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during WAIT discards the write.
    pre = {mem_m[32], mem_m[33], mem_m[34], mem_m[35]};
    start(1'b1, 32'h20, 4'b1111, ~pre, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ce = 1'b0;
    @(negedge clk);
    check("abort_ack", ack, 1'b0);
    check("abort_stall", stall, 1'b0);
    check("abort_err", err, 1'b0);
    check("abort_data", rdata, 32'h0);
    last_rd = '0;
    rst = 1'b1;
    @(negedge clk);
    access(1'b0, 32'h20, 4'b1111, 32'h0, 1'b0);
    check("abort_no_write", rdata, pre);

    // Out-of-range write, then word 0.
    access(1'b1, 32'h40, 4'b1111, 32'h55667788, 1'b0);
    access(1'b0, 32'h0, 4'b1111, 32'h0, 1'b0);

    // Flush mid-WAIT still completes the write.
    access(1'b1, 32'h8, 4'b1111, 32'hDEADBEEF, 1'b1);
    access(1'b0, 32'h8, 4'b1111, 32'h0, 1'b0);
    check("t6_flush_write", rdata, 32'hDEADBEEF);

    // Randomized accesses, including out-of-range and random lane masks.
    for (int i = 0; i < 60; i++) begin
      access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 2 * NB - 1)),
             4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
